// File: rtl/mul_add_module.sv
// Sequential radix-2 shift-add multiply-accumulate: result = q*divisor + r.
// Rebuilds a dividend from divider outputs and compares it with an expected value.
module mul_add_module #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   r,
  input  logic [WIDTH-1:0]   expected,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               match,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    DONE  = 2'd2,
    REARM = 2'd3
  } state_t;

  state_t             state_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [WIDTH-1:0]   exp_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_next_s;

  // Accumulator value after the current iteration's conditional add
  always_comb begin
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Control FSM, datapath registers and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      exp_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= {(2*WIDTH){1'b0}};
      match    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      // Status flags lag the state by one edge so done lands WIDTH+1 edges after start
      busy <= (state_r == CALC) || (state_r == DONE);
      done <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r  <= {{WIDTH{1'b0}}, q};
            mplier_r <= divisor;
            acc_r    <= {{WIDTH{1'b0}}, r};
            exp_r    <= expected;
            cnt_r    <= {CW{1'b0}};
            state_r  <= CALC;
          end else begin
            state_r  <= IDLE;
          end
        end
        CALC: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            result  <= acc_next_s;
            match   <= (acc_next_s == {{WIDTH{1'b0}}, exp_r});
            ovf     <= |acc_next_s[2*WIDTH-1:WIDTH];
            state_r <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          state_r <= REARM;
        end
        REARM: begin
          if (!start) begin
            state_r <= IDLE;
          end else begin
            state_r <= REARM;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_add_module.sv
// Scoreboard bench for mul_add_module: expectations are queued at start and
// popped by a monitor on each done pulse.
module tb_mul_add_module;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   r;
  logic [WIDTH-1:0]   expected;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               match;
  logic               ovf;

  typedef struct {
    logic [2*WIDTH-1:0] res;
    logic               m;
    logic               o;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   done_cnt     = 0;
  int   busy_run     = 0;

  mul_add_module #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .q(q), .divisor(divisor), .r(r),
    .expected(expected), .busy(busy), .done(done), .result(result),
    .match(match), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: pop one expectation per done pulse
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (busy) busy_run++;
    else busy_run = 0;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("result", 32'(result), 32'(e.res));
        check_val("match", 32'(match), 32'(e.m));
        check_val("ovf", 32'(ovf), 32'(e.o));
        check_val("latency", 32'(cyc - e.cyc), 32'(WIDTH + 1));
        check_val("busy_cycles", 32'(busy_run), 32'(WIDTH + 1));
      end
    end
  end

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] e, input int at);
    exp_t x;
    x.res = (2*WIDTH)'(a) * (2*WIDTH)'(b) + (2*WIDTH)'(c);
    x.m   = (x.res == (2*WIDTH)'(e));
    x.o   = (x.res[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    x.cyc = at;
    return x;
  endfunction

  // Drive one start edge, queue its expectation and bound-wait for done
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] e, input bit scramble);
    int prev;
    int n;
    @(posedge clk); #1;
    q = a; divisor = b; r = c; expected = e; start = 1'b1;
    sb.push_back(model(a, b, c, e, cyc + 1));
    prev = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cnt == prev && n < 40) begin
      if (scramble) begin
        q = WIDTH'($urandom); divisor = WIDTH'($urandom);
        r = WIDTH'($urandom); expected = WIDTH'($urandom);
      end
      @(posedge clk); #3;
      n++;
    end
    check_val("done_seen", 32'(done_cnt - prev), 32'd1);
  endtask

  initial begin
    int prev;
    int n;
    exp_t held;
    rst = 1'b1; start = 1'b0; q = '0; divisor = '0; r = '0; expected = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_match", 32'(match), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    run_op(8'd13, 8'd8, 8'd5, 8'd109, 1'b0);
    run_op(8'd255, 8'd255, 8'd255, 8'd0, 1'b0);
    run_op(8'd0, 8'd200, 8'd7, 8'd7, 1'b0);
    run_op(8'd9, 8'd0, 8'd0, 8'd0, 1'b0);
    run_op(8'd201, 8'd77, 8'd31, 8'd12, 1'b1);

    // start held high: one done only, then parked
    @(posedge clk); #1;
    q = 8'd21; divisor = 8'd11; r = 8'd3; expected = 8'd234; start = 1'b1;
    sb.push_back(model(8'd21, 8'd11, 8'd3, 8'd234, cyc + 1));
    prev = done_cnt;
    repeat (40) @(posedge clk);
    #3;
    check_val("held_one_done", 32'(done_cnt - prev), 32'd1);
    check_val("parked_busy", 32'(busy), 32'd0);
    check_val("parked_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    q = 8'd100; divisor = 8'd3; r = 8'd9; expected = 8'd0; start = 1'b1;
    sb.push_back(model(8'd100, 8'd3, 8'd9, 8'd0, cyc + 1));
    prev = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cnt == prev && n < 40) begin
      @(posedge clk); #3;
      n++;
    end
    check_val("rearm_done", 32'(done_cnt - prev), 32'd1);

    // reset at iteration 4 aborts without a done pulse
    held = model(8'd100, 8'd3, 8'd9, 8'd0, 0);
    @(posedge clk); #1;
    q = 8'd50; divisor = 8'd50; r = 8'd1; expected = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("hold_result", 32'(result), 32'(held.res));
    @(posedge clk); #1;
    rst = 1'b1;
    prev = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_result", 32'(result), 32'd0);
    check_val("abort_match", 32'(match), 32'd0);
    check_val("abort_ovf", 32'(ovf), 32'd0);
    repeat (15) @(posedge clk);
    #3;
    check_val("abort_no_done", 32'(done_cnt - prev), 32'd0);
    run_op(8'd50, 8'd50, 8'd1, 8'd0, 1'b0);

    for (int qi = 0; qi < 32; qi++) begin
      for (int ri = 0; ri < 8; ri++) begin
        run_op(8'(qi), 8'd8, 8'(ri), 8'(8 * qi + ri), 1'b0);
      end
    end

    repeat (4) @(posedge clk);
    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
